// File: rtl/multicycle_ripple_adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle ripple adder.
// The chunk count and index width are derived here so the top and bench agree.
package multicycle_ripple_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_chunks(input int numbits, input int chunkbits);
        return numbits / chunkbits;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int nchunks);
        return (nchunks > 1) ? $clog2(nchunks) : 1;
    endfunction

endpackage

// File: rtl/multicycle_ripple_adder_if.sv
// Operand/result handshake bundle for the multi-cycle ripple adder.
// The producer/consumer side uses master, the adder itself uses slave.
interface multicycle_ripple_adder_if #(
    parameter int NUMBITS = 64
);

    logic               in_valid;
    logic               in_ready;
    logic [NUMBITS-1:0] A;
    logic [NUMBITS-1:0] B;
    logic               sub;
    logic               carry_in;
    logic               out_valid;
    logic               out_ready;
    logic [NUMBITS-1:0] result;
    logic               carryout;
    logic               overflow;

    modport master (
        output in_valid, A, B, sub, carry_in, out_ready,
        input  in_ready, out_valid, result, carryout, overflow
    );

    modport slave (
        input  in_valid, A, B, sub, carry_in, out_ready,
        output in_ready, out_valid, result, carryout, overflow
    );

endinterface

// File: rtl/multicycle_ripple_adder_chunk_adder.sv
// Combinational CHUNKBITS-wide ripple carry adder used for one chunk per cycle.
// msb_carry_in exposes the carry into the top bit for signed-overflow detection.
module multicycle_ripple_adder_chunk_adder #(
    parameter int CHUNKBITS = 8
) (
    input  logic [CHUNKBITS-1:0] a,
    input  logic [CHUNKBITS-1:0] b,
    input  logic                 cin,
    output logic [CHUNKBITS-1:0] sum,
    output logic                 cout,
    output logic                 msb_carry_in
);

    logic [CHUNKBITS:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < CHUNKBITS; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout         = carry[CHUNKBITS];
    assign msb_carry_in = carry[CHUNKBITS-1];

endmodule

// File: rtl/multicycle_ripple_adder.sv
// Adds or subtracts two NUMBITS operands CHUNKBITS per clock, carrying between
// chunks through a register; valid/ready handshakes on both sides.
module multicycle_ripple_adder
    import multicycle_ripple_adder_pkg::*;
#(
    parameter int NUMBITS   = 64,
    parameter int CHUNKBITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_ripple_adder_if.slave  bus
);

    localparam int NUMCHUNKS = num_chunks(NUMBITS, CHUNKBITS);
    localparam int IDXW      = idx_width(NUMCHUNKS);

    if (NUMBITS % CHUNKBITS != 0) begin : g_illegal_params
        $error("multicycle_ripple_adder: NUMBITS (%0d) must be a multiple of CHUNKBITS (%0d)",
               NUMBITS, CHUNKBITS);
    end

    state_e               state_q, state_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic                 carry_q, carry_d;
    logic [NUMBITS-1:0]   a_q, a_d;
    logic [NUMBITS-1:0]   b_q, b_d;
    logic [NUMBITS-1:0]   result_q, result_d;
    logic                 carryout_q, carryout_d;
    logic                 overflow_q, overflow_d;
    logic                 out_valid_q, out_valid_d;

    logic [CHUNKBITS-1:0] a_chunk, b_chunk, chunk_sum;
    logic                 chunk_cout, chunk_msb_cin;

    assign a_chunk = a_q[int'(idx_q) * CHUNKBITS +: CHUNKBITS];
    assign b_chunk = b_q[int'(idx_q) * CHUNKBITS +: CHUNKBITS];

    multicycle_ripple_adder_chunk_adder #(
        .CHUNKBITS (CHUNKBITS)
    ) u_chunk_adder (
        .a            (a_chunk),
        .b            (b_chunk),
        .cin          (carry_q),
        .sum          (chunk_sum),
        .cout         (chunk_cout),
        .msb_carry_in (chunk_msb_cin)
    );

    // Subtraction is A + ~B + ~borrow, so B is inverted and the carry flipped at accept.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carryout_d  = carryout_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.sub ? ~bus.B : bus.B;
                    carry_d = bus.carry_in ^ bus.sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[int'(idx_q) * CHUNKBITS +: CHUNKBITS] = chunk_sum;
                carry_d = chunk_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDXW'(NUMCHUNKS - 1)) begin
                    carryout_d  = chunk_cout;
                    // Same-sign operands giving a different-sign sum is exactly carry-into-MSB != carry-out.
                    overflow_d  = chunk_msb_cin ^ chunk_cout;
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carryout_q  <= carryout_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carryout  = carryout_q;
    assign bus.overflow  = overflow_q;

endmodule
